// File: rtl/xg_axis_pkg.sv
// Shared widths, types and helpers for the 10G AXI-Stream egress stages.
// Helpers work on max-width vectors so one function serves every parameterisation.
package xg_axis_pkg;

   localparam int XG_AXIS_DATA_WIDTH   = 256;
   localparam int XG_AXIS_TUSER_WIDTH  = 128;
   localparam int XG_TIME_STAMP_DWIDTH = 64;
   localparam int XG_MAX_TS_WIDTH      = 256;
   localparam int XG_MAX_STRB_WIDTH    = 128;

   typedef enum logic {
      ST_SOP,
      ST_MID
   } ts_state_e;

   // Byte i of the result is byte (n_bytes-1-i) of ts, so the MSB lands in the lowest lane.
   function automatic logic [XG_MAX_TS_WIDTH-1:0] ts_byte_reverse(
      input logic [XG_MAX_TS_WIDTH-1:0] ts,
      input int                         n_bytes
   );
      logic [XG_MAX_TS_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < XG_MAX_TS_WIDTH/8; i++) begin
         if (i < n_bytes) r[i*8 +: 8] = ts[(n_bytes-1-i)*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [XG_MAX_STRB_WIDTH-1:0] strb_window_mask(
      input int offset,
      input int n_bytes
   );
      logic [XG_MAX_STRB_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < XG_MAX_STRB_WIDTH; i++) begin
         m[i] = (i >= offset) && (i < offset + n_bytes);
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: output register plus skid register,
// with a registered ready so nothing combinational crosses the stage.
module axis_skid_buffer #(
   parameter int PKT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PKT_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [PKT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [PKT_WIDTH-1:0] skid_data;
   logic                 skid_valid;
   logic                 in_fire;
   logic                 out_free;

   assign in_fire  = in_valid & in_ready;
   assign out_free = out_ready | ~out_valid;

   // in_ready always tracks the next value of ~skid_valid; it is held low during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else if (out_free) begin
         if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_fire;
            if (in_fire) out_data <= in_data;
         end
         in_ready <= 1'b1;
      end else if (in_fire) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
         in_ready   <= 1'b0;
      end else begin
         in_ready <= ~skid_valid;
      end
   end

endmodule

// File: rtl/tx_timestamp_insert.sv
// Egress stage that writes the time-stamp counter, MSB first, into a fixed byte
// window of each packet's first beat and counts stamped / skipped packets.
module tx_timestamp_insert
   import xg_axis_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = XG_AXIS_DATA_WIDTH,
   parameter int C_AXIS_TUSER_WIDTH = XG_AXIS_TUSER_WIDTH,
   parameter int TIME_STAMP_DWIDTH  = XG_TIME_STAMP_DWIDTH,
   parameter int TS_OFFSET_BYTES    = 16,
   parameter int C_CNT_WIDTH        = 32
) (
   input  logic                            axi_aclk,
   input  logic                            axi_resetn,
   input  logic [TIME_STAMP_DWIDTH-1:0]    counter_val,
   input  logic                            stamp_en,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [C_CNT_WIDTH-1:0]          stamped_count,
   output logic [C_CNT_WIDTH-1:0]          skipped_count
);

   localparam int STRB_W   = C_AXIS_DATA_WIDTH/8;
   localparam int TS_BYTES = TIME_STAMP_DWIDTH/8;
   localparam int PKT_W    = C_AXIS_DATA_WIDTH + STRB_W + C_AXIS_TUSER_WIDTH + 1;

   ts_state_e                    state;
   logic [XG_MAX_TS_WIDTH-1:0]   ts_rev_full;
   logic [XG_MAX_STRB_WIDTH-1:0] win_mask_full;
   logic                         win_ok;
   logic                         accept;
   logic                         do_stamp;
   logic [C_AXIS_DATA_WIDTH-1:0] stamped_tdata;
   logic [PKT_W-1:0]             skid_in;
   logic [PKT_W-1:0]             skid_out;
   logic                         unused_helper_bits;

   assign ts_rev_full   = ts_byte_reverse(XG_MAX_TS_WIDTH'(counter_val), TS_BYTES);
   assign win_mask_full = strb_window_mask(TS_OFFSET_BYTES, TS_BYTES);
   assign win_ok        = &(s_axis_tstrb | ~win_mask_full[STRB_W-1:0]);
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign do_stamp      = (state == ST_SOP) && stamp_en && win_ok;

   // The helpers return max-width vectors; only the low lanes matter here.
   assign unused_helper_bits = &{1'b0, ts_rev_full, win_mask_full};

   // Only the window bytes of a stamped first beat change; everything else passes through.
   always_comb begin
      stamped_tdata = s_axis_tdata;
      if (do_stamp) begin
         for (int i = 0; i < TS_BYTES; i++) begin
            stamped_tdata[(TS_OFFSET_BYTES+i)*8 +: 8] = ts_rev_full[i*8 +: 8];
         end
      end
   end

   // Packet framing and statistics; the stamp decision is taken once per packet in SOP.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state         <= ST_SOP;
         stamped_count <= '0;
         skipped_count <= '0;
      end else if (accept) begin
         if (state == ST_SOP) begin
            if (stamp_en && win_ok)  stamped_count <= stamped_count + C_CNT_WIDTH'(1);
            if (stamp_en && !win_ok) skipped_count <= skipped_count + C_CNT_WIDTH'(1);
            state <= s_axis_tlast ? ST_SOP : ST_MID;
         end else if (s_axis_tlast) begin
            state <= ST_SOP;
         end
      end
   end

   assign skid_in = {stamped_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};

   axis_skid_buffer #(
      .PKT_WIDTH (PKT_W)
   ) u_skid (
      .clk       (axi_aclk),
      .rst_n     (axi_resetn),
      .in_data   (skid_in),
      .in_valid  (s_axis_tvalid),
      .in_ready  (s_axis_tready),
      .out_data  (skid_out),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = skid_out;

endmodule

// File: doc/tx_timestamp_insert.md
Name: tx_timestamp_insert

Overview:
Egress stage directly downstream of the data path's port-0 master stream, in front of the 10G MAC TX interface. Writes the free-running time-stamp counter value into a fixed byte window of each packet's first beat; all other beats pass through unchanged. Adds one register stage with a skid buffer, so it sustains one beat per cycle under back-pressure. Keeps wrap-around counts of stamped and skipped packets for software.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width in bits; tstrb width is C_AXIS_DATA_WIDTH/8.
C_AXIS_TUSER_WIDTH, 128, tuser width; tuser is passed through unmodified.
TIME_STAMP_DWIDTH, 64, timestamp width; must be a multiple of 8.
TS_OFFSET_BYTES, 48 mod 32 not allowed; default 16, byte index of the first stamp byte within beat 0; TS_OFFSET_BYTES + TIME_STAMP_DWIDTH/8 <= C_AXIS_DATA_WIDTH/8.
C_CNT_WIDTH, 32, width of the statistics counters.

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  reset; asynchronous assert, active-low
counter_val  in  TIME_STAMP_DWIDTH  free-running time stamp, axi_aclk domain
stamp_en  in  1  1 = stamp packets; sampled per packet at its first beat
s_axis_tdata  in  C_AXIS_DATA_WIDTH  input beat data
s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  input byte strobes
s_axis_tuser  in  C_AXIS_TUSER_WIDTH  input sideband
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of packet
m_axis_tdata  out  C_AXIS_DATA_WIDTH  output data
m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  output strobes
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  output sideband
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end of packet
stamped_count  out  C_CNT_WIDTH  packets stamped
skipped_count  out  C_CNT_WIDTH  packets not stamped because stamp_en=1 but the window strobes were incomplete

Behaviour:
- Reset (axi_resetn=0, asynchronous):
  - m_axis_tvalid=0; all m_axis data, strobe, user and last registers are 0.
  - s_axis_tready=0 while reset is asserted, 1 in the first cycle after deassertion.
  - Both counters are 0; the FSM is in SOP; the skid buffer is empty.
- Reset mid-packet discards everything held. After reset, the next accepted beat is treated as a first beat.
- Handshake follows AXI4-Stream:
  - A beat transfers when valid & ready are both high.
  - m_axis_* stays stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- Pipeline: 2-entry skid buffer (output register plus skid register).
  - s_axis_tready is registered and equals ~skid_valid.
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
  - Throughput is 1 beat/cycle while m_axis_tready=1.
- FSM, two states:
  - SOP: waiting for the first beat. Accepting a beat with tlast=0 goes to MID; with tlast=1 stays in SOP (single-beat packet).
  - MID: accepting a beat with tlast=1 goes to SOP; otherwise stays in MID.
- Stamp decision, made only on a beat accepted in SOP:
  - win_ok = all s_axis_tstrb bits [TS_OFFSET_BYTES +: TIME_STAMP_DWIDTH/8] are 1.
  - stamp_en=1 and win_ok: stamp the beat; stamped_count += 1.
  - stamp_en=1 and not win_ok: pass the beat unmodified; skipped_count += 1.
  - stamp_en=0: pass unmodified; neither counter changes.
- Stamp format, network byte order: output byte TS_OFFSET_BYTES+i (bits [8k+7:8k], k = TS_OFFSET_BYTES+i) = counter_val[TIME_STAMP_DWIDTH-1-8i -: 8].
  - counter_val is the value present in the acceptance cycle.
  - Bytes outside the window, tstrb, tuser and tlast are unchanged.
- Beats accepted in MID are never modified.
- Counters wrap from 2^C_CNT_WIDTH-1 to 0 without saturation. They update in the acceptance cycle, so the new value is visible on the next cycle.
- stamp_en changing mid-packet has no effect on that packet.

Decomposition:
- Shared package (xg_axis_pkg):
  - default widths: 256, 128, 64;
  - a function returning the byte-reversed timestamp;
  - a function returning the strobe window mask for a given offset and width.
- One sub-module, axis_skid_buffer, parameterised on a packed {tdata,tstrb,tuser,tlast} width. It is reusable by the pkt_count and output-queue stages.
- Stamp logic and FSM live in tx_timestamp_insert.

Test Plan:
- Single 3-beat packet, stamp_en=1, full strobes, counter_val=0x0102030405060708 at beat-0 acceptance -> beat 0 bytes 16..23 = 01,02,...,08; other bytes and beats 1-2 bit-identical; stamped_count=1; first m_axis_tvalid 1 cycle after acceptance.
- Back-to-back 1-beat packets with m_axis_tready toggling 1,0,0,1 -> no beat lost or duplicated, output held stable while stalled, s_axis_tready drops only once the skid register is full; each packet stamped with the counter value from its own acceptance cycle.
- 1-beat packet, tstrb=0x0000FFFF (bytes 16-31 invalid), stamp_en=1 -> data unmodified; skipped_count=1; stamped_count=0.
- stamp_en=0 on a 4-beat packet, raised to 1 at beat 2 -> whole packet unmodified; both counters unchanged; next packet is stamped.
- axi_resetn pulsed low during beat 1 of a 3-beat packet -> m_axis_tvalid=0 and counters=0 immediately (asynchronous); first beat accepted after reset is stamped.
- Force stamped_count to 0xFFFFFFFF via 2^32-1 stamped packets (or a backdoor preload), then one more stamped packet -> stamped_count=0.
